// File: rtl/control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch, decode and per-instruction
// execute steps and drives the datapath mux selects and write enables.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       ir_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_dest;
        logic       i_or_d;
        logic       alu_src_a;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   live;

    function automatic logic [2:0] alu_decode(input logic [5:0] f);
        case (f)
            6'b100000: alu_decode = 3'b010;
            6'b100010: alu_decode = 3'b110;
            6'b100100: alu_decode = 3'b000;
            6'b100101: alu_decode = 3'b001;
            6'b101010: alu_decode = 3'b111;
            default:   alu_decode = 3'b010;
        endcase
    endfunction

    function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c             = '0;
        c.alu_control = 3'b010;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR, ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMREAD: c.i_or_d = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_decode(f);
            end
            ALUWB: begin
                c.reg_dest  = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q;
    // funct for EXECUTE is therefore captured on the DECODE->EXECUTE edge.
    always_comb ctrl_d = ctrl_decode(state_d, funct);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_decode(FETCH, 6'd0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Enables drop immediately under reset and in any unencoded state.
    assign live = ~reset & (state_q <= JUMP);

    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign reg_dest    = ctrl_q.reg_dest;
    assign i_or_d      = ctrl_q.i_or_d;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign ir_write    = ctrl_q.ir_write  & live;
    assign mem_write   = ctrl_q.mem_write & live;
    assign pc_write    = ctrl_q.pc_write  & live;
    assign branch      = ctrl_q.branch    & live;
    assign reg_write   = ctrl_q.reg_write & live;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign pc_src      = ctrl_q.pc_src;
    assign alu_control = ctrl_q.alu_control;
    assign state       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model (state path per opcode plus
// per-state output table) driven with directed and randomized instruction streams.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_to_reg, reg_dest, i_or_d, alu_src_a;
    logic       ir_write, mem_write, pc_write, branch, reg_write;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
        .ir_write(ir_write), .mem_write(mem_write), .pc_write(pc_write), .branch(branch),
        .reg_write(reg_write), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .state(state)
    );

    always #5 clk = ~clk;

    // {mem_to_reg,reg_dest,i_or_d,alu_src_a,ir_write,mem_write,pc_write,branch,reg_write,alu_src_b,pc_src,alu_control}
    logic [15:0] obs;
    logic [4:0]  enables;
    assign obs = {mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write, pc_write,
                  branch, reg_write, alu_src_b, pc_src, alu_control};
    assign enables = {ir_write, mem_write, pc_write, branch, reg_write};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sequence of states an instruction visits, starting at FETCH.
    function automatic void model_path(input logic [5:0] op, output int n, output int st[6]);
        st = '{0, 1, 0, 0, 0, 0};
        case (op)
            6'b100011: begin n = 5; st[2] = 2; st[3] = 3; st[4] = 4; end
            6'b101011: begin n = 4; st[2] = 2; st[3] = 5; end
            6'b000000: begin n = 4; st[2] = 6; st[3] = 7; end
            6'b001000: begin n = 4; st[2] = 9; st[3] = 10; end
            6'b000100: begin n = 3; st[2] = 8; end
            6'b000010: begin n = 3; st[2] = 11; end
            default:   n = 2;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int s, input logic [5:0] fn);
        logic m2r = 0, rd = 0, iod = 0, sa = 0, irw = 0, mw = 0, pcw = 0, br = 0, rw = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (s)
            0:  begin sb = 2'b01; irw = 1; pcw = 1; end
            1:  sb = 2'b11;
            2, 9: begin sa = 1; sb = 2'b10; end
            3:  iod = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iod = 1; mw = 1; end
            6: begin
                sa = 1;
                if (fn == 6'b100010) alu = 3'b110;
                else if (fn == 6'b100100) alu = 3'b000;
                else if (fn == 6'b100101) alu = 3'b001;
                else if (fn == 6'b101010) alu = 3'b111;
            end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; alu = 3'b110; ps = 2'b01; br = 1; end
            10: rw = 1;
            11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {m2r, rd, iod, sa, irw, mw, pcw, br, rw, sb, ps, alu};
    endfunction

    // Runs one instruction from FETCH; with noise, inputs are scrambled in unsampled states.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit noise);
        int n;
        int st[6];
        model_path(op, n, st);
        for (int i = 0; i < n; i++) begin
            if (noise && !(st[i] == 1 || st[i] == 2 || st[i] == 6)) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end else begin
                opcode = op;
                funct  = fn;
            end
            n_checks++;
            if (state !== 4'(st[i])) begin
                n_fail++;
                $display("FAIL state op=%b step=%0d: got %0d expected %0d", op, i, state, st[i]);
            end
            n_checks++;
            if (obs !== exp_out(st[i], fn)) begin
                n_fail++;
                $display("FAIL outputs op=%b fn=%b state=%0d: got %h expected %h",
                         op, fn, st[i], obs, exp_out(st[i], fn));
            end
            n_checks++;
            if (mem_write && reg_write) begin
                n_fail++;
                $display("FAIL write_exclusive state=%0d: got mem_write=1 reg_write=1 expected at most one", state);
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (state !== 4'd0 || enables !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got state=%0d enables=%b expected state=0 enables=00000", state, enables);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || obs !== exp_out(0, 6'd0)) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d outputs=%h expected state=0 outputs=%h",
                     state, obs, exp_out(0, 6'd0));
        end
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, 1'b0);
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b101010, 1'b0);
        run_instr(6'b000000, 6'b100010, 1'b0);
        run_instr(6'b000000, 6'b100100, 1'b0);
        run_instr(6'b000000, 6'b100101, 1'b0);
        run_instr(6'b000000, 6'b111000, 1'b0);
    endtask

    task automatic test_beq_j();
        run_instr(6'b000100, 6'b000000, 1'b0);
        run_instr(6'b000010, 6'b000000, 1'b0);
    endtask

    task automatic test_unknown();
        run_instr(6'b111111, 6'b000000, 1'b0);
        run_instr(6'b101011, 6'b000000, 1'b0);
        run_instr(6'b001000, 6'b000000, 1'b0);
    endtask

    task automatic test_reset_mid();
        opcode = 6'b101011;
        funct  = 6'd0;
        step();
        step();
        step();
        n_checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_reach_memwrite: got state=%0d mem_write=%b expected state=5 mem_write=1", state, mem_write);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || enables !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_memwrite: got enables=%b expected 00000", enables);
        end
        step();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got %0d expected 0", state);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== exp_out(0, 6'd0)) begin
            n_fail++;
            $display("FAIL reset_mid_release: got %h expected %h", obs, exp_out(0, 6'd0));
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        int k = int'($urandom_range(0, 6));
        return (k == 6) ? 6'($urandom) : ops[k];
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        int k = int'($urandom_range(0, 5));
        return (k == 5) ? 6'($urandom) : fns[k];
    endfunction

    task automatic test_random();
        for (int i = 0; i < 200; i++)
            run_instr(pick_op(), pick_funct(), i[0]);
    endtask

    task automatic test_reset_random();
        for (int r = 0; r < 12; r++) begin
            logic [5:0] op = pick_op();
            int n;
            int st[6];
            int k;
            model_path(op, n, st);
            k = int'($urandom_range(0, n - 1));
            opcode = op;
            funct  = pick_funct();
            for (int i = 0; i < k; i++) step();
            reset = 1'b1;
            #1;
            n_checks++;
            if (enables !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_rand_enables state=%0d: got %b expected 00000", st[k], enables);
            end
            step();
            n_checks++;
            if (state !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_rand_state from=%0d: got %0d expected 0", st[k], state);
            end
            reset = 1'b0;
            #1;
            run_instr(pick_op(), pick_funct(), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq_j();
        test_unknown();
        test_reset_mid();
        test_random();
        test_reset_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
